// File: rtl/clk_div_chk.sv
// clk_div_chk: checks a divided clock sampled in its source clock domain.
// Emits edge strobes, measures period/high time, tracks lock and counts bad periods.
module clk_div_chk #(
    parameter int CLK_DIV  = 4,
    parameter int DUTY_NUM = 2,
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div_in,
    input  logic             chk_en,
    output logic             rise_pls,
    output logic             fall_pls,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             locked,
    output logic             err,
    output logic             err_pls,
    output logic [7:0]       err_cnt
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ACQ   = 3'd1;
    localparam logic [2:0] TRACK = 3'd2;
    localparam logic [2:0] LOCK  = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] PER_NOM = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] HI_NOM  = CNT_W'(DUTY_NUM);
    localparam logic [CNT_W-1:0] PER_TO  = CNT_W'(2 * CLK_DIV);
    localparam logic [GW-1:0]    LOCK_N  = GW'(LOCK_CNT);

    logic             in_q, seen_q, seen_d;
    logic             rise_pls_q, fall_pls_q, locked_q, err_q;
    logic             err_pls_q, err_pls_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] meas_period_q, meas_period_d, meas_high_q, meas_high_d;
    logic [2:0]       state_q, state_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d, good_inc;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             rise, fall, checking, timeout, good, bad;

    always_comb begin
        rise          = clk_div_in & ~in_q;
        fall          = ~clk_div_in & in_q;
        checking      = (state_q == TRACK) || (state_q == LOCK);
        timeout       = checking && !rise && (per_cnt_q == PER_TO);
        // meas_high_q still holds the high time from the period being closed
        good          = (per_cnt_q == PER_NOM) && (meas_high_q == HI_NOM);
        bad           = checking && (rise ? !good : timeout);
        seen_d        = seen_q | rise;
        hi_cnt_d      = rise ? CNT_W'(1) :
                        (clk_div_in && hi_cnt_q != CNT_MAX) ? hi_cnt_q + 1'b1 : hi_cnt_q;
        meas_high_d   = fall ? hi_cnt_q : meas_high_q;
        per_cnt_d     = (rise || timeout) ? CNT_W'(1) :
                        (per_cnt_q != CNT_MAX) ? per_cnt_q + 1'b1 : per_cnt_q;
        meas_period_d = (rise && seen_q) ? per_cnt_q : meas_period_q;
        good_inc      = good_cnt_q + GW'(1);
        state_d       = state_q;
        good_cnt_d    = good_cnt_q;
        if (!chk_en) begin
            state_d    = IDLE;
            good_cnt_d = '0;
        end else if (state_q == IDLE) begin
            state_d    = ACQ;
            good_cnt_d = '0;
        end else if (state_q == ACQ && rise) begin
            state_d    = TRACK;
            good_cnt_d = '0;
        end else if (state_q == TRACK && bad) begin
            good_cnt_d = '0;
        end else if (state_q == TRACK && rise) begin
            good_cnt_d = good_inc;
            state_d    = (good_inc == LOCK_N) ? LOCK : TRACK;
        end else if (state_q == LOCK && bad) begin
            state_d    = ERR;
        end
        err_pls_d     = bad;
        // a bad period coinciding with chk_en dropping is still counted
        err_cnt_d     = (state_q == IDLE && chk_en) ? 8'd0 :
                        (bad && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q          <= 1'b0;
            seen_q        <= 1'b0;
            rise_pls_q    <= 1'b0;
            fall_pls_q    <= 1'b0;
            hi_cnt_q      <= '0;
            per_cnt_q     <= '0;
            meas_period_q <= '0;
            meas_high_q   <= '0;
            state_q       <= IDLE;
            good_cnt_q    <= '0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            err_pls_q     <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            in_q          <= clk_div_in;
            seen_q        <= seen_d;
            rise_pls_q    <= rise;
            fall_pls_q    <= fall;
            hi_cnt_q      <= hi_cnt_d;
            per_cnt_q     <= per_cnt_d;
            meas_period_q <= meas_period_d;
            meas_high_q   <= meas_high_d;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            locked_q      <= (state_d == LOCK);
            err_q         <= (state_d == ERR);
            err_pls_q     <= err_pls_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign rise_pls    = rise_pls_q;
    assign fall_pls    = fall_pls_q;
    assign meas_period = meas_period_q;
    assign meas_high   = meas_high_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign err_pls     = err_pls_q;
    assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_clk_div_chk.sv
// tb_clk_div_chk: directed bench; expectations per rise are queued before driving
// and popped when the checker emits rise_pls.
module tb_clk_div_chk;
    logic       clk = 1'b0;
    logic       rst, clk_div_in, chk_en;
    logic       rise_pls, fall_pls, locked, err, err_pls;
    logic [4:0] meas_period, meas_high;
    logic [7:0] err_cnt;

    typedef struct {
        logic       ep;
        logic       lk;
        logic       er;
        logic [7:0] ec;
        int         mp;
        int         mh;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    clk_div_chk #(.CLK_DIV(4), .DUTY_NUM(2), .LOCK_CNT(3), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .clk_div_in(clk_div_in), .chk_en(chk_en),
        .rise_pls(rise_pls), .fall_pls(fall_pls), .meas_period(meas_period),
        .meas_high(meas_high), .locked(locked), .err(err), .err_pls(err_pls),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v);
        exp_t e;
        @(negedge clk);
        clk_div_in = v;
        @(posedge clk);
        #1;
        if (rise_pls) begin
            n_run++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_rise: observed rise_pls=1 expected 0");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("err_pls@rise", err_pls, e.ep);
                chk("locked@rise", locked, e.lk);
                chk("err@rise", err, e.er);
                chk("err_cnt@rise", err_cnt, e.ec);
                if (e.mp >= 0) chk("meas_period@rise", meas_period, e.mp);
                if (e.mh >= 0) chk("meas_high@rise", meas_high, e.mh);
            end
        end
    endtask

    task automatic exp_rise(input logic ep, lk, er, input logic [7:0] ec, input int mp, mh);
        exp_t e;
        e = '{ep: ep, lk: lk, er: er, ec: ec, mp: mp, mh: mh};
        sb.push_back(e);
    endtask

    task automatic pat(input int hi, lo, input logic ep, lk, er, input logic [7:0] ec,
                       input int mp, mh);
        exp_rise(ep, lk, er, ec, mp, mh);
        for (int i = 0; i < hi; i++) begin
            step(1'b1);
            if (i == 0) chk("rise_pls", rise_pls, 1);
        end
        for (int i = 0; i < lo; i++) step(1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {rise_pls, fall_pls, meas_period, meas_high, locked, err, err_pls, err_cnt}, 0);
    endtask

    initial begin
        rst = 1'b1;
        chk_en = 1'b0;
        clk_div_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_outputs");
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        step(1'b0);
        step(1'b0);
        // nominal lock on the 4th rise
        pat(2, 2, 0, 0, 0, 0, 0, 0);
        pat(2, 2, 0, 0, 0, 0, 4, 2);
        pat(2, 2, 0, 0, 0, 0, 4, 2);
        pat(2, 2, 0, 1, 0, 0, 4, 2);
        pat(2, 2, 0, 1, 0, 0, 4, 2);
        // one long period while locked
        pat(2, 3, 0, 1, 0, 0, 4, 2);
        pat(2, 2, 1, 0, 1, 1, 5, 2);
        pat(2, 2, 0, 0, 1, 1, 4, 2);
        chk_en = 1'b0;
        step(1'b0);
        chk("idle_err", err, 0);
        chk("idle_locked", locked, 0);
        chk("idle_err_cnt", err_cnt, 1);
        chk_en = 1'b1;
        step(1'b0);
        chk("acq_err_cnt_clr", err_cnt, 0);
        // wrong duty 1110, then saturation
        pat(3, 1, 0, 0, 0, 0, -1, -1);
        for (int k = 1; k <= 300; k++)
            pat(3, 1, 1, 0, 0, (k > 255) ? 8'd255 : 8'(k), 4, 3);
        chk("sat_err_cnt", err_cnt, 255);
        // asynchronous reset in the middle of a high phase
        exp_rise(1, 0, 0, 255, 4, 3);
        step(1'b1);
        #2 rst = 1'b1;
        #1;
        chk_zero("async_reset_outputs");
        clk_div_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1'b0);
        pat(2, 2, 0, 0, 0, 0, 0, 0);
        pat(2, 2, 0, 0, 0, 0, 4, 2);
        pat(2, 2, 0, 0, 0, 0, 4, 2);
        pat(2, 2, 0, 1, 0, 0, 4, 2);
        // stall while locked
        pat(2, 2, 0, 1, 0, 0, 4, 2);
        for (int i = 4; i < 8; i++) begin
            step(1'b0);
            chk("stall_lock_no_err", err_pls, 0);
        end
        step(1'b0);
        chk("stall_lock_err_pls", err_pls, 1);
        chk("stall_lock_locked", locked, 0);
        chk("stall_lock_err", err, 1);
        chk("stall_lock_err_cnt", err_cnt, 1);
        // stall while tracking repeats every 8 cycles
        chk_en = 1'b0;
        step(1'b0);
        chk_en = 1'b1;
        step(1'b0);
        pat(2, 2, 0, 0, 0, 0, -1, 2);
        for (int i = 4; i <= 20; i++) begin
            step(1'b0);
            chk("stall_track_err_pls", err_pls, (i % 8 == 0) ? 1 : 0);
            chk("stall_track_err_cnt", err_cnt, i / 8);
            chk("stall_track_err", err, 0);
        end
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_div_chk.md
# clk_div_chk

Divided-clock checker for the MBIST testbench clocking. It sits directly downstream of the divided-clock generator and samples its output in the fast clock domain. It emits one-cycle rise/fall strobes, measures period and high time, and checks both against expected values. It asserts `locked` after a run of good periods and flags and counts deviations.

## Interface
Parameters:
- `CLK_DIV`, 4: expected period, in `clk` cycles.
- `DUTY_NUM`, 2: expected high time, in `clk` cycles.
- `LOCK_CNT`, 3: consecutive good periods required to lock.
- `CNT_W`, 5: measurement counter width. 2*`CLK_DIV` must be ≤ 2^`CNT_W`−1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input, 1: fast clock. This is the same clock that drives the divider.
- `rst` input, 1: asynchronous active-high reset.
- `clk_div_in` input, 1: divided clock. It is synchronous to `clk`, so no synchronizer is used.
- `chk_en` input, 1: checker enable, level-sensitive.
- `rise_pls` output, 1: one-cycle strobe per rising edge of `clk_div_in`.
- `fall_pls` output, 1: one-cycle strobe per falling edge of `clk_div_in`.
- `meas_period` output, `CNT_W`: last measured period, rise to rise.
- `meas_high` output, `CNT_W`: last measured high time.
- `locked` output, 1: high in state LOCK.
- `err` output, 1: high in state ERR (sticky error).
- `err_pls` output, 1: one-cycle pulse per bad period.
- `err_cnt` output, 8: saturating count of bad periods.

## Operation
Edge detection:
- `in_q` holds `clk_div_in` from the previous edge.
- A rise event occurs when `clk_div_in`=1 and `in_q`=0. A fall event occurs when `clk_div_in`=0 and `in_q`=1.
- Edge detection runs in every state.

Counters (all saturate at all-ones):
- High counter `hi_cnt`:
  - On a rise event, `hi_cnt` is set to 1.
  - While the input is sampled high with no rise event, `hi_cnt` increments.
  - On a fall event, `meas_high` is loaded with `hi_cnt`.
- Period counter `per_cnt`:
  - On a rise event, `meas_period` is loaded with `per_cnt` (only if a previous rise has been seen since reset), and `per_cnt` is set to 1.
  - Otherwise `per_cnt` increments.
- Nominal 1100 input gives `meas_high`=2 and `meas_period`=4.

Period check, in TRACK and LOCK only:
- The check runs on each rise event.
- A period is good when `per_cnt`==`CLK_DIV` and `meas_high`==`DUTY_NUM`. The `meas_high` value used is the one already registered, i.e. from the fall inside the period being closed.
- A timeout occurs when `per_cnt`==2*`CLK_DIV` with no rise event in that cycle. A timeout counts as a bad period and restarts `per_cnt` at 1.
- For every bad period: `err_pls` pulses and `err_cnt` increments, saturating at 255.

State machine (reset state IDLE):
- IDLE: `good_cnt` is 0. When `chk_en`=1, go to ACQ and clear `err_cnt`. Otherwise `err_cnt` holds its value.
- ACQ: on the first rise event, go to TRACK with `good_cnt`=0. No checks are made in ACQ.
- TRACK:
  - Good period: `good_cnt`++. When `good_cnt` reaches `LOCK_CNT`, go to LOCK.
  - Bad period: `good_cnt` is cleared and the state stays TRACK.
- LOCK: a bad period moves to ERR.
- ERR: holds until `chk_en`=0.
- `chk_en`=0 in any state goes to IDLE at the next edge. This has priority over all other transitions.

## Timing
- All outputs are registered. Every output resets to 0: the strobes, `meas_*`, `locked`, `err`, `err_cnt`, and state IDLE.
- Edge-detect latency:
  - If the edge at time k samples a rise, `rise_pls` is high for exactly the cycle after edge k. `fall_pls` behaves the same way.
  - For nominal input, consecutive `rise_pls` are `CLK_DIV` cycles apart.
- The state update, `err_pls`, the `err_cnt` increment and the `meas_period` load occur at the same edge as the rise (or timeout) detection. They become visible in the same cycle as `rise_pls`.
- `locked` rises together with the `rise_pls` of the (`LOCK_CNT`+1)-th rise after entering ACQ.
- `locked` falls and `err` rises together with the `err_pls` of the first bad period in LOCK.
- Asserting `rst` mid-operation clears everything asynchronously. After release, the block re-acquires from IDLE. The first period after release is never checked.
- `chk_en` dropping on the same edge as a bad period: the block goes to IDLE, while `err_pls` and the `err_cnt` increment still take effect.

## Test plan
- **Reset:** `rst`=1 mid-pattern → all outputs 0. Release with `chk_en`=1 and nominal 1100 → first `rise_pls`, no `err_pls`.
- **Nominal lock:** `chk_en`=1, input 1100 repeated → `locked`=1 with the 4th `rise_pls`, `meas_period`=4, `meas_high`=2, `err_cnt`=0, `err`=0.
- **Wrong duty:** input 1110 repeated → `err_pls` on every rise from the 2nd onward, `err_cnt` counts 1, 2, 3…, `locked` stays 0, `meas_high`=3.
- **Loss of lock:** lock, then one 11000 period → `err_pls`, `locked`=0, `err`=1, `err_cnt`=1, `meas_period`=5. Resume 1100 → stays ERR. Drop `chk_en` → IDLE, `err`=0, `err_cnt` stays 1. Raise `chk_en` → `err_cnt`=0.
- **Stall:** lock, then hold input 0 → `err_pls` 8 cycles after the last rise, then ERR. In TRACK, a stall repeats `err_pls` every 8 cycles.
- **Saturation:** 300 bad periods in TRACK → `err_cnt`=255 and holding.
